// File: rtl/veopixel_pkg.sv
// Shared types and defaults for the WS2812-style one-wire pixel decoder.
//   pixel_t : 24-bit GRB pixel, first-received bit in bit 23
//   state_e : decoder FSM states
//   Def*    : default timing and counter-width parameters (50 MHz clock)
package veopixel_pkg;

   localparam int unsigned PixelBits    = 24;
   localparam int unsigned DefThreshCyc = 30;    // T0H=20, T1H=40 cycles
   localparam int unsigned DefLatchCyc  = 2500;  // 50 us of continuous low
   localparam int unsigned DefCntW      = 16;

   typedef logic [PixelBits-1:0] pixel_t;

   typedef enum logic [1:0] {
      StIdle,  // waiting for the first latch after reset
      StLow,
      StHigh
   } state_e;

endpackage

// File: rtl/veopixel_sync.sv
// Two-flop synchronizer for the asynchronous serial input, plus single-cycle
// rise/fall pulses derived from the synchronized level.
//   clk   in  : clock
//   rst_n in  : synchronous active-low reset
//   din   in  : asynchronous serial data
//   sync  out : synchronized din (2 cycles of latency)
//   rise  out : pulse in the first cycle sync is high
//   fall  out : pulse in the first cycle sync is low
module veopixel_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= din;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign sync = sync_q;
   assign rise = sync_q & ~prev_q;
   assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/veopixel_decoder.sv
// WS2812-style one-wire pixel decoder. Measures each synchronized high pulse,
// decodes long pulses as 1 and short as 0, assembles 24-bit GRB pixels MSB
// first and detects the frame latch (long continuous low).
//   clk         in  : clock, all logic on rising edge
//   rst_n       in  : synchronous active-low reset
//   din         in  : asynchronous serial input
//   pixel       out : last complete pixel (GRB, first bit in bit 23)
//   pixel_valid out : one-cycle pulse when pixel updates
//   pixel_count out : pixels completed in the current frame (saturating)
//   frame_end   out : one-cycle pulse on latch detection
//   err         out : pulse with frame_end when 1-23 bits were pending
//   dout        out : forwarded stream, only when VEOPIXEL_FORWARD_EN is
//                     defined; otherwise tied low
module veopixel_decoder
   import veopixel_pkg::*;
#(
   parameter int unsigned THRESH_CYC = DefThreshCyc,
   parameter int unsigned LATCH_CYC  = DefLatchCyc,
   parameter int unsigned CNT_W      = DefCntW
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             din,
   output logic [23:0]      pixel,
   output logic             pixel_valid,
   output logic [CNT_W-1:0] pixel_count,
   output logic             frame_end,
   output logic             err,
   output logic             dout
);

   localparam int unsigned      BcntW     = $clog2(PixelBits);
   localparam logic [BcntW-1:0] BitLast   = BcntW'(PixelBits - 1);
   localparam logic [CNT_W-1:0] LatchVal  = CNT_W'(LATCH_CYC);
   localparam logic [CNT_W-1:0] ThreshVal = CNT_W'(THRESH_CYC);
   localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

   logic sync, rise, fall;

   veopixel_sync u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (din),
      .sync  (sync),
      .rise  (rise),
      .fall  (fall)
   );

   state_e           state_q, state_d;
   logic [CNT_W-1:0] hcnt_q, hcnt_d;
   logic [CNT_W-1:0] lcnt_q, lcnt_d;
   logic [CNT_W-1:0] pcnt_q, pcnt_d;
   logic [BcntW-1:0] bcnt_q, bcnt_d;
   pixel_t           shreg_q, shreg_d;
   pixel_t           pixel_q, pixel_d;
   logic             pvalid_q, pvalid_d;
   logic             fend_q, fend_d;
   logic             err_q, err_d;
   logic             bit_val;
   logic             low_sat;
   logic             latch_hit;

   // Low counter parks at LatchVal so a latch is reported once per low run.
   assign low_sat   = (lcnt_q == LatchVal);
   assign latch_hit = !sync && (lcnt_q == LatchVal - 1'b1);

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (latch_hit) state_d = StLow;
         StLow:   if (rise)      state_d = StHigh;
         StHigh:  if (fall)      state_d = StLow;
         default:                state_d = StIdle;
      endcase
   end

   // Counters, shift register and registered output pulses
   always_comb begin
      hcnt_d   = hcnt_q;
      lcnt_d   = lcnt_q;
      pcnt_d   = pcnt_q;
      bcnt_d   = bcnt_q;
      shreg_d  = shreg_q;
      pixel_d  = pixel_q;
      pvalid_d = 1'b0;
      fend_d   = 1'b0;
      err_d    = 1'b0;
      bit_val  = (hcnt_q >= ThreshVal);
      unique case (state_q)
         StIdle: begin
            // Any high restarts the search for an uninterrupted latch.
            lcnt_d = sync ? '0 : (low_sat ? lcnt_q : lcnt_q + 1'b1);
         end
         StLow: begin
            if (rise) begin
               hcnt_d = CntOne;
            end else if (!low_sat) begin
               lcnt_d = lcnt_q + 1'b1;
               if (latch_hit) begin
                  fend_d = 1'b1;
                  err_d  = (bcnt_q != '0);
                  bcnt_d = '0;
                  pcnt_d = '0;
               end
            end
         end
         StHigh: begin
            if (fall) begin
               shreg_d = {shreg_q[PixelBits-2:0], bit_val};
               lcnt_d  = CntOne;
               // The 24th bit goes straight into pixel; the bit counter
               // never holds 24.
               if (bcnt_q == BitLast) begin
                  pixel_d  = shreg_d;
                  pvalid_d = 1'b1;
                  bcnt_d   = '0;
                  if (pcnt_q != '1) pcnt_d = pcnt_q + 1'b1;
               end else begin
                  bcnt_d = bcnt_q + 1'b1;
               end
            end else if (hcnt_q != '1) begin
               hcnt_d = hcnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hcnt_q   <= '0;
         lcnt_q   <= '0;
         pcnt_q   <= '0;
         bcnt_q   <= '0;
         shreg_q  <= '0;
         pixel_q  <= '0;
         pvalid_q <= 1'b0;
         fend_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         hcnt_q   <= hcnt_d;
         lcnt_q   <= lcnt_d;
         pcnt_q   <= pcnt_d;
         bcnt_q   <= bcnt_d;
         shreg_q  <= shreg_d;
         pixel_q  <= pixel_d;
         pvalid_q <= pvalid_d;
         fend_q   <= fend_d;
         err_q    <= err_d;
      end
   end

   assign pixel       = pixel_q;
   assign pixel_valid = pvalid_q;
   assign pixel_count = pcnt_q;
   assign frame_end   = fend_q;
   assign err         = err_q;

`ifdef VEOPIXEL_FORWARD_EN
   // Consume the first pixel of each frame, then pass the synchronized line
   // through one extra flop until the latch.
   logic pass_q, pass_d;
   logic dout_q;

   always_comb begin
      pass_d = pass_q;
      if (fend_d) begin
         pass_d = 1'b0;
      end else if (pvalid_d) begin
         pass_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pass_q <= 1'b0;
         dout_q <= 1'b0;
      end else begin
         pass_q <= pass_d;
         dout_q <= pass_q & sync;
      end
   end

   assign dout = dout_q;
`else
   assign dout = 1'b0;
`endif

endmodule
